// File: rtl/wb_arbiter2.sv
// rtl/wb_arbiter2.sv - two-master round-robin arbiter for the pipelined Wishbone bus
//
// Master A (CPU) and master B (debug loader / DMA) share one slave fabric.
// The bus is granted per cyc transaction with round-robin tie breaking and
// one cycle of grant latency. The arbiter tracks outstanding requests,
// throttles stb at MAX_OUT, and returns responses only to the granted master.
//
// Optional feature macro: WB_ARB_TIMEOUT_EN (slave timeout -> bus error + ABORT)
//
// Ports:
//   i_clk, i_resetn                      clock, synchronous active-low reset
//   a_cyc/a_stb/a_we/a_addr/a_mosi/a_sel master A request
//   a_ack/a_stall/a_err/a_miso           master A response
//   b_*                                  master B, same shape as master A
//   o_wb_cyc/stb/we/addr/mosi/sel        request towards the slave fabric
//   i_wb_ack/stall/err/miso              response from the slave fabric
module wb_arbiter2 #(
  parameter int AW      = 30,
  parameter int DW      = 32,
  parameter int MAX_OUT = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_resetn,
  input  logic              a_cyc,
  input  logic              a_stb,
  input  logic              a_we,
  input  logic [AW-1:0]     a_addr,
  input  logic [DW-1:0]     a_mosi,
  input  logic [DW/8-1:0]   a_sel,
  output logic              a_ack,
  output logic              a_stall,
  output logic              a_err,
  output logic [DW-1:0]     a_miso,
  input  logic              b_cyc,
  input  logic              b_stb,
  input  logic              b_we,
  input  logic [AW-1:0]     b_addr,
  input  logic [DW-1:0]     b_mosi,
  input  logic [DW/8-1:0]   b_sel,
  output logic              b_ack,
  output logic              b_stall,
  output logic              b_err,
  output logic [DW-1:0]     b_miso,
  output logic              o_wb_cyc,
  output logic              o_wb_stb,
  output logic              o_wb_we,
  output logic [AW-1:0]     o_wb_addr,
  output logic [DW-1:0]     o_wb_mosi,
  output logic [DW/8-1:0]   o_wb_sel,
  input  logic              i_wb_ack,
  input  logic              i_wb_stall,
  input  logic              i_wb_err,
  input  logic [DW-1:0]     i_wb_miso
);

  localparam int            CW      = $clog2(MAX_OUT) + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);

  if (MAX_OUT < 1 || MAX_OUT > 16 || (MAX_OUT & (MAX_OUT - 1)) != 0 || TIMEOUT < 1) begin : g_bad_cfg
    $error("wb_arbiter2: MAX_OUT must be a power of two in 1..16 and TIMEOUT >= 1");
  end

`ifdef WB_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, GNT_A, GNT_B, ABORT} state_t;
`else
  typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;
`endif

  state_t        state, state_d;
  logic          rr_last, rr_last_d;   // last granted master: 0 = A, 1 = B
  logic [CW-1:0] count, count_d;       // accepted but not yet acked/erred
  logic          resp_ok;              // a response is only meaningful with something outstanding
  logic          full;
  logic          accept;
  logic          retire;
  logic          release_bus;
  logic          tmo_hit;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = (state == GNT_A || state == GNT_B) && (tmo_cnt == TW'(TIMEOUT));

  // Counts response-free cycles while something is outstanding.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      tmo_cnt <= '0;
    end else if (!(state == GNT_A || state == GNT_B) || count == '0 ||
                 i_wb_ack || i_wb_err || tmo_hit) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state;
    rr_last_d   = rr_last;
    o_wb_cyc    = 1'b0;
    o_wb_stb    = 1'b0;
    o_wb_we     = 1'b0;
    o_wb_addr   = '0;
    o_wb_mosi   = '0;
    o_wb_sel    = '0;
    a_ack       = 1'b0;
    a_err       = 1'b0;
    a_stall     = 1'b1;
    a_miso      = '0;
    b_ack       = 1'b0;
    b_err       = 1'b0;
    b_stall     = 1'b1;
    b_miso      = '0;
    release_bus = 1'b0;
    resp_ok     = (count != '0);
    full        = (count == MAX_CNT);

    case (state)
      IDLE: begin
        // On a tie, the master that was not granted last wins.
        if (a_cyc && (!b_cyc || rr_last)) begin
          state_d   = GNT_A;
          rr_last_d = 1'b0;
        end else if (b_cyc) begin
          state_d   = GNT_B;
          rr_last_d = 1'b1;
        end
      end
      GNT_A: begin
        o_wb_cyc  = a_cyc;
        o_wb_stb  = a_stb && !full;
        o_wb_we   = a_we;
        o_wb_addr = a_addr;
        o_wb_mosi = a_mosi;
        o_wb_sel  = a_sel;
        a_stall   = i_wb_stall || full;
        a_ack     = i_wb_ack && resp_ok;
        a_err     = i_wb_err && resp_ok;
        a_miso    = i_wb_miso;
        if (!a_cyc) begin
          release_bus = 1'b1;
          if (b_cyc) begin
            state_d   = GNT_B;
            rr_last_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
`ifdef WB_ARB_TIMEOUT_EN
        else if (tmo_hit) begin
          state_d = ABORT;
        end
`endif
      end
      GNT_B: begin
        o_wb_cyc  = b_cyc;
        o_wb_stb  = b_stb && !full;
        o_wb_we   = b_we;
        o_wb_addr = b_addr;
        o_wb_mosi = b_mosi;
        o_wb_sel  = b_sel;
        b_stall   = i_wb_stall || full;
        b_ack     = i_wb_ack && resp_ok;
        b_err     = i_wb_err && resp_ok;
        b_miso    = i_wb_miso;
        if (!b_cyc) begin
          release_bus = 1'b1;
          if (a_cyc) begin
            state_d   = GNT_A;
            rr_last_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
`ifdef WB_ARB_TIMEOUT_EN
        else if (tmo_hit) begin
          state_d = ABORT;
        end
`endif
      end
`ifdef WB_ARB_TIMEOUT_EN
      ABORT: begin
        // rr_last still names the master that owned the hung transaction.
        a_err   = !rr_last;
        b_err   = rr_last;
        state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase

    accept = o_wb_stb && !i_wb_stall;
    retire = (i_wb_ack || i_wb_err) && resp_ok;

    // Dropping cyc abandons everything in flight; late responses then see count=0.
    if (release_bus || tmo_hit) begin
      count_d = '0;
    end else if (accept && !retire) begin
      count_d = count + CW'(1);
    end else if (retire && !accept) begin
      count_d = count - CW'(1);
    end else begin
      count_d = count;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      state   <= IDLE;
      rr_last <= 1'b1;
      count   <= '0;
    end else begin
      state   <= state_d;
      rr_last <= rr_last_d;
      count   <= count_d;
    end
  end

endmodule
